// File: rtl/tail_light_pkg.sv
// Shared types for the tail-light sequencer: the controller state encoding.
package tail_light_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEQ_L   = 3'd1,
        SEQ_R   = 3'd2,
        HAZ_ON  = 3'd3,
        HAZ_OFF = 3'd4
    } state_t;

endpackage

// File: rtl/tail_light_seq_tick_prescaler.sv
// Divides clk down to a one-cycle step strobe every TICK_DIV cycles.
module tick_prescaler #(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PCNT_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PCNT_ONE  = PW'(1);

    logic [PW-1:0] pcnt_q;
    logic [PW-1:0] pcnt_d;

    // Strobe on the last count and wrap back to zero.
    always_comb begin
        tick = (pcnt_q == PCNT_LAST);
        if (tick) begin
            pcnt_d = '0;
        end else begin
            pcnt_d = pcnt_q + PCNT_ONE;
        end
    end

    // Prescaler count register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/tail_light_seq.sv
// Turn-signal / hazard / brake tail-lamp sequencer driving NLAMPS lamps per side.
module tail_light_seq
    import tail_light_pkg::*;
#(
    parameter int NLAMPS   = 3,
    parameter int TICK_DIV = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              left,
    input  logic              right,
    input  logic              hazard,
    input  logic              brake,
    output logic [NLAMPS-1:0] lamp_l,
    output logic [NLAMPS-1:0] lamp_r
);

    localparam int SW = (NLAMPS > 0) ? $clog2(NLAMPS + 1) : 1;
    localparam logic [SW-1:0] STEP_ONE  = SW'(1);
    localparam logic [SW-1:0] STEP_LAST = SW'(NLAMPS);

    state_t          state_q;
    state_t          state_d;
    logic [SW-1:0]   step_q;
    logic [SW-1:0]   step_d;
    logic            brake_q;
    logic            tick;
    logic            haz_req;
    logic [NLAMPS-1:0] thermo;
    logic [NLAMPS-1:0] brake_vec;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    // State, step and brake registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            step_q  <= '0;
            brake_q <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            brake_q <= brake;
        end
    end

    // Next-state logic; requests are only looked at on tick edges.
    always_comb begin
        haz_req = hazard | (left & right);
        state_d = state_q;
        step_d  = step_q;
        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (haz_req) begin
                        state_d = HAZ_ON;
                        step_d  = '0;
                    end else if (left) begin
                        state_d = SEQ_L;
                        step_d  = STEP_ONE;
                    end else if (right) begin
                        state_d = SEQ_R;
                        step_d  = STEP_ONE;
                    end else begin
                        state_d = IDLE;
                        step_d  = '0;
                    end
                end
                SEQ_L, SEQ_R: begin
                    if (hazard) begin
                        state_d = HAZ_ON;
                        step_d  = '0;
                    end else if (step_q == STEP_LAST) begin
                        state_d = IDLE;
                        step_d  = '0;
                    end else begin
                        state_d = state_q;
                        step_d  = step_q + STEP_ONE;
                    end
                end
                HAZ_ON: begin
                    step_d = '0;
                    if (haz_req) begin
                        state_d = HAZ_OFF;
                    end else begin
                        state_d = IDLE;
                    end
                end
                HAZ_OFF: begin
                    step_d = '0;
                    if (haz_req) begin
                        state_d = HAZ_ON;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    step_d  = '0;
                end
            endcase
        end else begin
            state_d = state_q;
            step_d  = step_q;
        end
    end

    // Lamp decode: thermometer fills from the innermost lamp outward.
    always_comb begin
        brake_vec = {NLAMPS{brake_q}};
        for (int i = 0; i < NLAMPS; i++) begin
            thermo[i] = (SW'(i) < step_q);
        end
        case (state_q)
            SEQ_L: begin
                lamp_l = thermo;
                lamp_r = brake_vec;
            end
            SEQ_R: begin
                lamp_l = brake_vec;
                lamp_r = thermo;
            end
            HAZ_ON: begin
                lamp_l = '1;
                lamp_r = '1;
            end
            HAZ_OFF: begin
                lamp_l = '0;
                lamp_r = '0;
            end
            IDLE: begin
                lamp_l = brake_vec;
                lamp_r = brake_vec;
            end
            default: begin
                lamp_l = '0;
                lamp_r = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_tail_light_seq.sv
// Directed bench: vector table on the 3-lamp/div-1 instance, hand sequences for
// prescaled stepping on a 5-lamp/div-4 instance and asynchronous reset abort.
module tb_tail_light_seq;

    logic       clk;
    logic       reset_n, left, right, hazard, brake;
    logic [2:0] lamp_l, lamp_r;
    logic       rst2_n, left2, right2, hazard2, brake2;
    logic [4:0] lamp_l2, lamp_r2;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct packed {
        logic       l, r, h, b;
        logic [2:0] el, er;
    } vec_t;

    vec_t tbl [0:34];

    tail_light_seq #(.NLAMPS(3), .TICK_DIV(1)) dut (
        .clk(clk), .reset_n(reset_n), .left(left), .right(right),
        .hazard(hazard), .brake(brake), .lamp_l(lamp_l), .lamp_r(lamp_r)
    );

    tail_light_seq #(.NLAMPS(5), .TICK_DIV(4)) dut2 (
        .clk(clk), .reset_n(rst2_n), .left(left2), .right(right2),
        .hazard(hazard2), .brake(brake2), .lamp_l(lamp_l2), .lamp_r(lamp_r2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        int p;
        tbl[0]  = '{1'b0,1'b0,1'b0,1'b0, 3'b000, 3'b000};
        tbl[1]  = '{1'b1,1'b0,1'b0,1'b0, 3'b001, 3'b000};
        tbl[2]  = '{1'b1,1'b0,1'b0,1'b0, 3'b011, 3'b000};
        tbl[3]  = '{1'b1,1'b0,1'b0,1'b0, 3'b111, 3'b000};
        tbl[4]  = '{1'b1,1'b0,1'b0,1'b0, 3'b000, 3'b000};
        tbl[5]  = '{1'b1,1'b0,1'b0,1'b0, 3'b001, 3'b000};
        tbl[6]  = '{1'b0,1'b0,1'b0,1'b0, 3'b011, 3'b000};
        tbl[7]  = '{1'b0,1'b1,1'b0,1'b0, 3'b111, 3'b000};
        tbl[8]  = '{1'b0,1'b1,1'b0,1'b0, 3'b000, 3'b000};
        tbl[9]  = '{1'b0,1'b1,1'b0,1'b0, 3'b000, 3'b001};
        tbl[10] = '{1'b0,1'b0,1'b0,1'b0, 3'b000, 3'b011};
        tbl[11] = '{1'b0,1'b0,1'b0,1'b0, 3'b000, 3'b111};
        tbl[12] = '{1'b0,1'b0,1'b0,1'b0, 3'b000, 3'b000};
        tbl[13] = '{1'b0,1'b0,1'b0,1'b0, 3'b000, 3'b000};
        tbl[14] = '{1'b1,1'b1,1'b0,1'b0, 3'b111, 3'b111};
        tbl[15] = '{1'b1,1'b1,1'b0,1'b0, 3'b000, 3'b000};
        tbl[16] = '{1'b1,1'b1,1'b0,1'b0, 3'b111, 3'b111};
        tbl[17] = '{1'b0,1'b0,1'b0,1'b0, 3'b000, 3'b000};
        tbl[18] = '{1'b1,1'b0,1'b0,1'b0, 3'b001, 3'b000};
        tbl[19] = '{1'b1,1'b0,1'b0,1'b0, 3'b011, 3'b000};
        tbl[20] = '{1'b0,1'b0,1'b1,1'b0, 3'b111, 3'b111};
        tbl[21] = '{1'b0,1'b0,1'b0,1'b0, 3'b000, 3'b000};
        tbl[22] = '{1'b0,1'b0,1'b0,1'b1, 3'b111, 3'b111};
        tbl[23] = '{1'b0,1'b0,1'b0,1'b0, 3'b000, 3'b000};
        tbl[24] = '{1'b1,1'b0,1'b0,1'b1, 3'b001, 3'b111};
        tbl[25] = '{1'b1,1'b0,1'b0,1'b1, 3'b011, 3'b111};
        tbl[26] = '{1'b1,1'b0,1'b0,1'b1, 3'b111, 3'b111};
        tbl[27] = '{1'b0,1'b0,1'b0,1'b1, 3'b111, 3'b111};
        tbl[28] = '{1'b0,1'b0,1'b1,1'b1, 3'b111, 3'b111};
        tbl[29] = '{1'b0,1'b0,1'b1,1'b1, 3'b000, 3'b000};
        tbl[30] = '{1'b0,1'b0,1'b0,1'b0, 3'b000, 3'b000};
        tbl[31] = '{1'b0,1'b1,1'b0,1'b0, 3'b000, 3'b001};
        tbl[32] = '{1'b0,1'b0,1'b1,1'b0, 3'b111, 3'b111};
        tbl[33] = '{1'b0,1'b0,1'b1,1'b0, 3'b000, 3'b000};
        tbl[34] = '{1'b0,1'b0,1'b0,1'b0, 3'b000, 3'b000};

        reset_n = 1'b0; left = 1'b0; right = 1'b0; hazard = 1'b0; brake = 1'b0;
        rst2_n = 1'b0; left2 = 1'b1; right2 = 1'b0; hazard2 = 1'b0; brake2 = 1'b0;

        // Reset state, including a brake request that must not show while held.
        brake = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold_l", int'(lamp_l), 0);
        check("reset_hold_r", int'(lamp_r), 0);
        @(negedge clk);
        brake = 1'b0;
        reset_n = 1'b1;
        #1;
        check("post_release_l", int'(lamp_l), 0);
        check("post_release_r", int'(lamp_r), 0);

        for (int i = 0; i <= 34; i++) begin
            @(negedge clk);
            left = tbl[i].l; right = tbl[i].r; hazard = tbl[i].h; brake = tbl[i].b;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_lamp_l", i), int'(lamp_l), int'(tbl[i].el));
            check($sformatf("vec%0d_lamp_r", i), int'(lamp_r), int'(tbl[i].er));
        end

        // Asynchronous reset in the middle of a left run.
        @(negedge clk);
        left = 1'b1;
        @(posedge clk); #1;
        check("arst_pre1_l", int'(lamp_l), 1);
        @(posedge clk); #1;
        check("arst_pre2_l", int'(lamp_l), 3);
        #1;
        reset_n = 1'b0;
        #1;
        check("arst_now_l", int'(lamp_l), 0);
        check("arst_now_r", int'(lamp_r), 0);
        @(posedge clk); #1;
        check("arst_held_l", int'(lamp_l), 0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("arst_rel_l", int'(lamp_l), 0);
        @(posedge clk); #1;
        check("arst_restart_l", int'(lamp_l), 1);
        check("arst_restart_r", int'(lamp_r), 0);
        @(posedge clk); #1;
        check("arst_restart2_l", int'(lamp_l), 3);

        // Prescaled 5-lamp instance: each pattern lasts four cycles.
        @(negedge clk);
        rst2_n = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            p = (k / 4) % 6;
            check($sformatf("div4_cyc%0d_lamp_l", k), int'(lamp_l2), (1 << p) - 1);
            check($sformatf("div4_cyc%0d_lamp_r", k), int'(lamp_r2), 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
